// File: rtl/serial_adder.sv
// serial_adder
//   Digit-serial adder: sum = x + y + cin over WIDTH bits, DIGIT bits per clock.
//   One operation takes N = WIDTH/DIGIT RUN cycles followed by a single DONE cycle.
//   The result is held until the next accepted start.
//
//   Optional feature macro: SERIAL_ADDER_OVF_EN
//     defined   : ovf reports signed overflow of the captured operands
//     undefined : ovf is tied low and no sign-capture registers exist
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request, sampled only while idle
//   x, y   in   WIDTH  operands, captured on an accepted start
//   cin    in   1      carry-in, captured on an accepted start
//   busy   out  1      high in RUN and DONE
//   done   out  1      one-cycle pulse, result valid
//   sum    out  WIDTH  result, valid from done, held while idle
//   carry  out  1      carry-out of bit WIDTH-1
//   ovf    out  1      signed overflow flag
//
// state  | meaning
// IDLE   | waiting for start, result held
// RUN    | adding one digit per edge
// DONE   | result valid for one cycle

module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = DIGIT + 1;

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [CW-1:0]    count;
    logic [DIGIT-1:0] dsum;
    logic             dcarry;
    logic             last;

    assign last = (count == CW'(N - 1));

    // One digit of the addition; carry doubles as the running carry register.
    always_comb begin
        {dcarry, dsum} = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + DW'(carry);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Datapath: operands shift right, result digits enter sum from the MSB end
    // so that after N edges the first digit has reached bit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            count <= '0;
            carry <= 1'b0;
            sum   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opa   <= x;
                        opb   <= y;
                        carry <= cin;
                        count <= '0;
                    end
                end
                S_RUN: begin
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    sum   <= (sum >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
                    carry <= dcarry;
                    count <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic xs;
    logic ys;
    logic ovf_q;

    // Operand signs are captured at start because the shift registers lose them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xs    <= 1'b0;
            ys    <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                xs <= x[WIDTH-1];
                ys <= y[WIDTH-1];
            end
            if (state == S_RUN && last) begin
                ovf_q <= (xs == ys) && (dsum[DIGIT-1] != xs);
            end
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
